cnna_udiv_seq_35ns_13ns_22: RTL and testbench

//   Sequential unsigned divider, the inverse of the 22x13->35 unsigned DSP multiply in the CNN datapath.

---
 rtl/cnna_udiv_seq_35ns_13ns_22_pkg.sv | 14 +
 rtl/cnna_udiv_seq_35ns_13ns_22_if.sv | 25 ++
 rtl/cnna_udiv_seq_35ns_13ns_22_step.sv | 19 +
 rtl/cnna_udiv_seq_35ns_13ns_22.sv | 109 ++++++++++
 tb/tb_cnna_udiv_seq_35ns_13ns_22.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/cnna_udiv_seq_35ns_13ns_22_pkg.sv
// rtl/cnna_udiv_seq_35ns_13ns_22_pkg.sv - shared widths, saturation value and FSM states for the divider
package cnna_div_pkg;
  localparam int DIVIDEND_W = 35;
  localparam int DIVISOR_W  = 13;
  localparam int QUOT_W     = 22;
  localparam int CNT_W      = 5;
  localparam logic [QUOT_W-1:0] QUOT_SAT = 22'h3FFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/cnna_udiv_seq_35ns_13ns_22_if.sv
// rtl/cnna_udiv_seq_35ns_13ns_22_if.sv - request/result bundle between the CNN datapath and the divider
interface cnna_udiv_seq_35ns_13ns_22_if;
  import cnna_div_pkg::*;

  logic                  ce;
  logic                  start;
  logic [DIVIDEND_W-1:0] din0;
  logic [DIVISOR_W-1:0]  din1;
  logic                  busy;
  logic                  done;
  logic [QUOT_W-1:0]     quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  overflow;
  logic                  div_by_zero;

  modport master (
    output ce, start, din0, din1,
    input  busy, done, quotient, remainder, overflow, div_by_zero
  );

  modport slave (
    input  ce, start, din0, din1,
    output busy, done, quotient, remainder, overflow, div_by_zero
  );
endinterface

// File: rtl/cnna_udiv_seq_35ns_13ns_22_step.sv
// rtl/cnna_udiv_seq_35ns_13ns_22_step.sv - one restoring-division iteration: shift in a dividend bit, trial-subtract
module cnna_udiv_step
  import cnna_div_pkg::*;
(
  input  logic [DIVISOR_W-1:0] i_r,
  input  logic                 i_q_msb,
  input  logic [DIVISOR_W-1:0] i_d,
  output logic [DIVISOR_W-1:0] o_r_next,
  output logic                 o_qbit
);
  logic [DIVISOR_W:0] w_shift;
  logic [DIVISOR_W:0] w_trial;

  assign w_shift  = {i_r, i_q_msb};
  assign w_trial  = w_shift - {1'b0, i_d};
  // A clear sign bit means the divisor fits; otherwise keep the shifted partial remainder.
  assign o_qbit   = ~w_trial[DIVISOR_W];
  assign o_r_next = o_qbit ? w_trial[DIVISOR_W-1:0] : w_shift[DIVISOR_W-1:0];
endmodule

// File: rtl/cnna_udiv_seq_35ns_13ns_22.sv
// rtl/cnna_udiv_seq_35ns_13ns_22.sv - radix-2 restoring 35/13 divider, 22-bit quotient, fixed 23-cycle latency
module cnna_udiv_seq_35ns_13ns_22
  import cnna_div_pkg::*;
#(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 35,
  parameter int din1_WIDTH = 13,
  parameter int dout_WIDTH = 22
) (
  input logic                         ap_clk,
  input logic                         ap_rst_n,
  cnna_udiv_seq_35ns_13ns_22_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QUOT_W);

  generate
    if (din0_WIDTH != DIVIDEND_W || din1_WIDTH != DIVISOR_W || dout_WIDTH != QUOT_W || ID < 0) begin : g_bad_param
      $error("cnna_udiv_seq_35ns_13ns_22: unsupported parameter set");
    end
  endgenerate

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  // Partial remainder stays below the divisor whenever the result is not saturated, so 13 bits suffice.
  logic [DIVISOR_W-1:0]  r_r;
  logic [QUOT_W-1:0]     r_q;
  logic [DIVISOR_W-1:0]  r_d;
  logic                  r_ovf;
  logic                  r_dz;
  logic [QUOT_W-1:0]     r_quotient;
  logic [DIVISOR_W-1:0]  r_remainder;
  logic                  r_overflow;
  logic                  r_div_by_zero;
  logic                  w_accept;
  logic [DIVISOR_W-1:0]  w_r_nxt;
  logic                  w_qbit;

  assign w_accept = bus.ce && bus.start && (r_state != RUN);

  cnna_udiv_step u_step (
    .i_r      (r_r),
    .i_q_msb  (r_q[QUOT_W-1]),
    .i_d      (r_d),
    .o_r_next (w_r_nxt),
    .o_qbit   (w_qbit)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state <= IDLE;
    end else if (bus.ce) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = RUN;
      RUN:     if (r_cnt == CNT_LAST) w_state_nxt = DONE;
      DONE:    w_state_nxt = w_accept ? RUN : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // RUN spends 22 cycles iterating and one more cycle publishing the result.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_cnt         <= '0;
      r_r           <= '0;
      r_q           <= '0;
      r_d           <= '0;
      r_ovf         <= 1'b0;
      r_dz          <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_overflow    <= 1'b0;
      r_div_by_zero <= 1'b0;
    end else if (bus.ce) begin
      if (w_accept) begin
        r_cnt <= '0;
        r_r   <= bus.din0[DIVIDEND_W-1:QUOT_W];
        r_q   <= bus.din0[QUOT_W-1:0];
        r_d   <= bus.din1;
        r_ovf <= (bus.din0[DIVIDEND_W-1:QUOT_W] >= bus.din1);
        r_dz  <= (bus.din1 == '0);
      end else if (r_state == RUN) begin
        if (r_cnt != CNT_LAST) begin
          r_r   <= w_r_nxt;
          r_q   <= {r_q[QUOT_W-2:0], w_qbit};
          r_cnt <= r_cnt + 1'b1;
        end else begin
          r_quotient    <= r_ovf ? QUOT_SAT : r_q;
          r_remainder   <= r_ovf ? '0 : r_r;
          r_overflow    <= r_ovf;
          r_div_by_zero <= r_dz;
        end
      end
    end
  end

  assign bus.busy        = (r_state == RUN);
  assign bus.done        = (r_state == DONE);
  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.overflow    = r_overflow;
  assign bus.div_by_zero = r_div_by_zero;
endmodule

// File: tb/tb_cnna_udiv_seq_35ns_13ns_22.sv
// tb/tb_cnna_udiv_seq_35ns_13ns_22.sv - directed self-checking bench for the sequential divider
module tb_cnna_udiv_seq_35ns_13ns_22;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  bit   got;
  int   lat;

  cnna_udiv_seq_35ns_13ns_22_if u_if ();

  cnna_udiv_seq_35ns_13ns_22 dut (
    .ap_clk   (clk),
    .ap_rst_n (rst_n),
    .bus      (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drives a request; returns at the negedge right after the accept edge.
  task automatic issue(input logic [34:0] a, input logic [12:0] b, input bit wait_neg);
    if (wait_neg) @(negedge clk);
    u_if.ce    = 1'b1;
    u_if.din0  = a;
    u_if.din1  = b;
    u_if.start = 1'b1;
    @(negedge clk);
    u_if.start = 1'b0;
  endtask

  // Counts ce=1 edges until done is seen; returns at the negedge where done is high.
  task automatic wait_done(input bit rnd, input int max, output bit seen, output int n);
    seen = 1'b0;
    n    = 0;
    for (int i = 0; i < max && !seen; i++) begin
      if (rnd) u_if.ce = 1'($urandom_range(0, 1));
      @(posedge clk);
      if (u_if.ce) n++;
      @(negedge clk);
      if (u_if.done) seen = 1'b1;
    end
  endtask

  task automatic check_result(input string tag, input logic [21:0] q, input logic [12:0] r,
                              input bit ovf, input bit dz);
    check({tag, ".done"},        64'(got), 64'd1);
    check({tag, ".quotient"},    64'(u_if.quotient), 64'(q));
    check({tag, ".remainder"},   64'(u_if.remainder), 64'(r));
    check({tag, ".overflow"},    64'(u_if.overflow), 64'(ovf));
    check({tag, ".div_by_zero"}, 64'(u_if.div_by_zero), 64'(dz));
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    u_if.ce    = 1'b1;
    u_if.start = 1'b0;
    u_if.din0  = '0;
    u_if.din1  = '0;
    repeat (3) @(negedge clk);
    check("reset.busy",        64'(u_if.busy), 64'd0);
    check("reset.done",        64'(u_if.done), 64'd0);
    check("reset.quotient",    64'(u_if.quotient), 64'd0);
    check("reset.remainder",   64'(u_if.remainder), 64'd0);
    check("reset.overflow",    64'(u_if.overflow), 64'd0);
    check("reset.div_by_zero", 64'(u_if.div_by_zero), 64'd0);
    rst_n = 1'b1;

    // 1) basic division and latency
    issue(35'd1000000, 13'd7, 1'b1);
    check("t1.busy", 64'(u_if.busy), 64'd1);
    wait_done(1'b0, 40, got, lat);
    check("t1.latency", 64'(lat), 64'd23);
    check_result("t1", 22'd142857, 13'd1, 1'b0, 1'b0);
    @(negedge clk);
    check("t1.done_pulse", 64'(u_if.done), 64'd0);

    // 2) largest quotient that still fits
    issue(35'd34355544063, 13'd8191, 1'b1);
    wait_done(1'b0, 40, got, lat);
    check_result("t2", 22'h3FFFFF, 13'd8190, 1'b0, 1'b0);

    // 3) overflow and divide-by-zero saturate after the full latency
    issue(35'd34359738367, 13'd8191, 1'b1);
    wait_done(1'b0, 40, got, lat);
    check("t3a.latency", 64'(lat), 64'd23);
    check_result("t3a", 22'h3FFFFF, 13'd0, 1'b1, 1'b0);
    issue(35'd12345, 13'd0, 1'b1);
    wait_done(1'b0, 40, got, lat);
    check_result("t3b", 22'h3FFFFF, 13'd0, 1'b1, 1'b1);

    // 4) start during RUN is ignored; start in DONE runs back-to-back
    issue(35'd1000000, 13'd7, 1'b1);
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    u_if.din0  = 35'd100;
    u_if.din1  = 13'd10;
    u_if.start = 1'b1;
    @(negedge clk);
    u_if.start = 1'b0;
    u_if.din0  = 35'd999;
    u_if.din1  = 13'd3;
    wait_done(1'b0, 40, got, lat);
    check("t4a.latency", 64'(lat), 64'd18);
    check_result("t4a", 22'd142857, 13'd1, 1'b0, 1'b0);
    issue(35'd100, 13'd10, 1'b0);
    check("t4b.busy", 64'(u_if.busy), 64'd1);
    check("t4b.done", 64'(u_if.done), 64'd0);
    wait_done(1'b0, 40, got, lat);
    check("t4b.latency", 64'(lat), 64'd23);
    check_result("t4b", 22'd10, 13'd0, 1'b0, 1'b0);

    // 5) random clock enable
    issue(35'd1000000, 13'd7, 1'b1);
    wait_done(1'b1, 200, got, lat);
    check("t5.latency", 64'(lat), 64'd23);
    check_result("t5", 22'd142857, 13'd1, 1'b0, 1'b0);
    u_if.ce = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("t5.done_held", 64'(u_if.done), 64'd1);
    end
    u_if.ce = 1'b1;
    @(negedge clk);
    check("t5.done_clear", 64'(u_if.done), 64'd0);

    // 6) asynchronous reset mid-operation
    issue(35'd1000000, 13'd7, 1'b1);
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    check("t6.busy",      64'(u_if.busy), 64'd0);
    check("t6.quotient",  64'(u_if.quotient), 64'd0);
    check("t6.remainder", 64'(u_if.remainder), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(35'd100, 13'd10, 1'b1);
    wait_done(1'b0, 40, got, lat);
    check_result("t6", 22'd10, 13'd0, 1'b0, 1'b0);

    // scoreboard against a reference division
    for (int k = 0; k < 8; k++) begin
      logic [34:0]     a;
      logic [12:0]     b;
      longint unsigned la;
      longint unsigned lb;
      logic [21:0]     eq;
      logic [12:0]     er;
      bit              eovf;
      b = 13'($urandom);
      a = 35'({$urandom, $urandom});
      if (k % 2 == 0 && b != 0) a = 35'(longint'(a) % (longint'(b) << 22));
      la   = longint'(a);
      lb   = longint'(b);
      eovf = (a[34:22] >= b);
      eq   = eovf ? 22'h3FFFFF : 22'(la / lb);
      er   = eovf ? 13'd0 : 13'(la % lb);
      issue(a, b, 1'b1);
      wait_done(1'b0, 40, got, lat);
      check_result($sformatf("rnd%0d", k), eq, er, eovf, b == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
